// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I opcode, immediate-format and reset constants
package rv32_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
endpackage

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: maps an RV32I opcode to its immediate format and flags non-base opcodes
module imm_src_decoder
  import rv32_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_src_t   imm_src,
  output logic       illegal
);
  always_comb begin
    imm_src = IMM_I;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_REG, OP_FENCE: imm_src = IMM_I;
      OP_STORE:         imm_src = IMM_S;
      OP_BRANCH:        imm_src = IMM_B;
      OP_JAL:           imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      default:          illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: PC register, instruction fetch and IF/ID pipeline register with immediate pre-decode
module if_id_stage
  import rv32_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0]          NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_f,
  input  logic                  stall_d,
  input  logic                  flush_d,
  input  logic                  pc_src_e,
  input  logic [DATA_WIDTH-1:0] pc_target_e,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr_d,
  output logic [DATA_WIDTH-1:0] pc_d,
  output logic [DATA_WIDTH-1:0] pc_plus4_d,
  output logic                  valid_d,
  output logic [31:7]           immediate_d,
  output logic [2:0]            imm_src_d,
  output logic                  illegal_d
);
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  imm_src_t              dec_src;
  logic                  dec_ill;
  assign pc_plus4    = pc + DATA_WIDTH'(4);
  assign imem_addr   = pc;
  assign immediate_d = instr_d[31:7];
  imm_src_decoder u_dec (
    .opcode  (imem_rdata[6:0]),
    .imm_src (dec_src),
    .illegal (dec_ill)
  );
  // a redirect beats stall_f so a taken branch is never dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else if (pc_src_e) pc <= {pc_target_e[DATA_WIDTH-1:2], 2'b00};
    else if (!stall_f) pc <= pc_plus4;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush_d) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
      imm_src_d  <= IMM_I;
      illegal_d  <= 1'b0;
    end else if (!stall_d) begin
      instr_d    <= imem_rdata;
      pc_d       <= pc;
      pc_plus4_d <= pc_plus4;
      valid_d    <= 1'b1;
      imm_src_d  <= dec_src;
      illegal_d  <= dec_ill;
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: table-driven scoreboard bench for the fetch stage and IF/ID register
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
  logic [31:0] pc_target_e = '0, imem_rdata = '0;
  logic [31:0] imem_addr, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, illegal_d;
  logic [31:7] immediate_d;
  logic [2:0]  imm_src_d;
  int tests = 0, fails = 0;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .immediate_d(immediate_d), .imm_src_d(imm_src_d), .illegal_d(illegal_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sf, sd, fl, ps;
    logic [31:0] tgt, rd, addr, instr, pcd;
    logic v;
    logic [2:0] src;
    logic ill;
  } vec_t;

  vec_t vecs[18];
  vec_t sb[$];

  function automatic vec_t mk(input logic sf, sd, fl, ps, input logic [31:0] tgt, rd, addr,
                              instr, pcd, input logic v, input logic [2:0] src, input logic ill);
    mk = '{sf, sd, fl, ps, tgt, rd, addr, instr, pcd, v, src, ill};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t x);
    chk({tag, " instr_d"}, instr_d, x.instr);
    chk({tag, " pc_d"}, pc_d, x.pcd);
    chk({tag, " pc_plus4_d"}, pc_plus4_d, x.v ? x.pcd + 32'd4 : 32'd0);
    chk({tag, " valid_d"}, {31'b0, valid_d}, {31'b0, x.v});
    chk({tag, " immediate_d"}, {7'b0, immediate_d}, x.instr >> 7);
    chk({tag, " imm_src_d"}, {29'b0, imm_src_d}, {29'b0, x.src});
    chk({tag, " illegal_d"}, {31'b0, illegal_d}, {31'b0, x.ill});
  endtask

  task automatic check_reset(input string tag);
    check_outputs(tag, mk(0, 0, 0, 0, 0, 0, 0, 32'h13, 0, 0, 3'b000, 0));
    chk({tag, " imem_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    vec_t x;
    //            sf sd fl ps tgt           rdata         addr          instr         pc_d          v src  ill
    vecs[0]  = mk(0, 0, 0, 0, 0,            32'h00500093, 32'h0,        32'h00500093, 32'h0,        1, 3'd0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0,            32'h00112623, 32'h4,        32'h00112623, 32'h4,        1, 3'd1, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0,            32'h00000463, 32'h8,        32'h00112623, 32'h4,        1, 3'd1, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0,            32'h00000463, 32'h8,        32'h00112623, 32'h4,        1, 3'd1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0,            32'h00000463, 32'h8,        32'h00000463, 32'h8,        1, 3'd2, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0,            32'h0080006F, 32'hC,        32'h0080006F, 32'hC,        1, 3'd3, 0);
    vecs[6]  = mk(1, 0, 1, 1, 32'h103,      32'h123450B7, 32'h10,       32'h00000013, 32'h0,        0, 3'd0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0,            32'h123450B7, 32'h100,      32'h123450B7, 32'h100,      1, 3'd4, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0,            32'h0000007F, 32'h104,      32'h0000007F, 32'h104,      1, 3'd0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0,            32'h00000033, 32'h108,      32'h00000033, 32'h108,      1, 3'd0, 0);
    vecs[10] = mk(0, 1, 1, 0, 0,            32'h0000000F, 32'h10C,      32'h00000013, 32'h0,        0, 3'd0, 0);
    vecs[11] = mk(0, 1, 0, 1, 32'hFFFFFFFF, 32'h00000073, 32'h110,      32'h00000013, 32'h0,        0, 3'd0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0,            32'h00100513, 32'hFFFFFFFC, 32'h00100513, 32'hFFFFFFFC, 1, 3'd0, 0);
    vecs[13] = mk(0, 0, 0, 1, 32'h200,      32'h00000073, 32'h0,        32'h00000073, 32'h0,        1, 3'd0, 0);
    vecs[14] = mk(0, 0, 0, 0, 0,            32'h00002003, 32'h200,      32'h00002003, 32'h200,      1, 3'd0, 0);
    vecs[15] = mk(1, 0, 0, 0, 0,            32'h00000017, 32'h204,      32'h00000017, 32'h204,      1, 3'd4, 0);
    vecs[16] = mk(0, 0, 0, 0, 0,            32'h00000067, 32'h204,      32'h00000067, 32'h204,      1, 3'd0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0,            32'h00000000, 32'h208,      32'h00000000, 32'h208,      1, 3'd0, 1);

    #12;
    check_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      {stall_f, stall_d, flush_d, pc_src_e} = {vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].ps};
      pc_target_e = vecs[i].tgt;
      imem_rdata  = vecs[i].rd;
      #1 chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("scoreboard empty", 32'd0, 32'd1);
      else begin
        x = sb.pop_front();
        check_outputs($sformatf("v%0d", i), x);
      end
    end

    // async reset in the middle of a stalled redirect, away from any clock edge
    @(negedge clk);
    {stall_f, stall_d, flush_d, pc_src_e} = 4'b1101;
    pc_target_e = 32'h300;
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    @(posedge clk);
    #1 check_reset("rst_held");
    @(negedge clk);
    {stall_f, stall_d, flush_d, pc_src_e} = 4'b0000;
    imem_rdata = 32'h00500093;
    rst_n = 1'b1;
    #1 chk("post_rst imem_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1 check_outputs("post_rst", mk(0, 0, 0, 0, 0, 0, 0, 32'h00500093, 32'h0, 1, 3'd0, 0));
    chk("post_rst next addr", imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end
endmodule
